branch_resolve_predict: RTL and testbench
=========================================

Name: branch_resolve_predict

Overview:
- Next-generation branch/PC-select block for the RV32I core. Replaces the single-cycle purely resolve-only PC select.
- Adds a parametrised bimodal branch history table (BHT) of saturating counters. The table is read at fetch to give a taken/not-taken prediction.
- At execute, resolves the actual outcome from Br_eq/Br_lt, drives PC_sel for redirect/recovery, flags mispredicts and trains the table.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, number of counters; power of two, 2..1024.
- CTR_W, 2, saturating counter width; 2..4.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch slot holds a valid PC
- if_pc  in  XLEN  fetch PC
- if_pred_taken  out  1  prediction for if_pc
- ex_valid  in  1  execute slot holds a valid instruction
- ex_instr  in  32  execute-stage instruction
- ex_pc  in  XLEN  execute-stage PC
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction
- Br_eq  in  1  comparator: rs1 == rs2
- Br_lt  in  1  comparator: rs1 < rs2, signedness per Br_un
- Br_un  out  1  unsigned-compare select to the comparator
- PC_sel  out  2  00 no redirect; 01 branch/JAL target; 10 JALR target; 11 ex_pc+4 recovery
- mispredict  out  1  redirect required this cycle
- illegal_br  out  1  branch opcode with reserved funct3

Behaviour:
- Index: IDX_W = log2(BHT_ENTRIES); idx = pc[IDX_W+1:2]. No tags; aliasing is accepted.
- Counters:
  - Reset value is weakly-not-taken: 2^(CTR_W-1)-1, e.g. 01 for CTR_W=2.
  - rst clears the whole array in the same cycle.
  - Prediction is the counter MSB.
- Fetch read:
  - if_pred_taken is combinational from the array when if_valid=1, else 0.
  - Read-during-write to the same index returns the pre-update value; no bypass.
- Decode at execute uses opcode = ex_instr[6:0] and funct3 = ex_instr[14:12].
- Branch (1100011):
  - Br_un = funct3[1].
  - taken: 000 Br_eq; 001 !Br_eq; 100/110 Br_lt; 101/111 !Br_lt.
  - Reserved funct3 010/011: taken=0, illegal_br=1, no BHT update, PC_sel=00.
- Branch resolution, only when ex_valid:
  - taken and !ex_pred_taken: PC_sel=01.
  - !taken and ex_pred_taken: PC_sel=11.
  - Otherwise PC_sel=00.
- JAL (1101111): PC_sel=01 when ex_valid, unless ex_pred_taken=1, in which case 00. No BHT update.
- JALR (1100111): PC_sel=10 always when ex_valid (target not predicted). No BHT update.
- Non-branch opcodes: Br_un=0, PC_sel=00, illegal_br=0.
- mispredict = ex_valid & (PC_sel != 00).
- Training:
  - On the clk edge with ex_valid, a valid branch and !rst, counter[idx(ex_pc)] increments if taken, else decrements.
  - Counters saturate at 0 and 2^CTR_W-1; no wrap.
- Output gating: ex_valid=0 forces PC_sel=00, mispredict=0, illegal_br=0, and no update.
- Reset mid-operation: rst has priority over a same-cycle update. The array returns to reset value next cycle.
- Combinational outputs carry no state, so they have no reset value; stats registers are 0 after reset.
- Latency:
  - Prediction: 0 cycles.
  - Resolution outputs: 0 cycles.
  - Training visible to fetch: 1 cycle after the update edge.

Optional Feature:
- Macro: BPU_STATS_EN.
- When defined, adds three outputs:
  - stat_branches [31:0]: count of resolved valid branches.
  - stat_mispred [31:0]: count of branch/JAL mispredicts, JALR excluded.
  - stat_jalr [31:0]: count of JALR redirects.
- Counter rules: all three reset to 0 on rst, wrap modulo 2^32, and update on the same edge as training.
- When undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then if_valid=1, if_pc=0x100 -> if_pred_taken=0; counter[0x100>>2 & 63] reads 01.
- BEQ at ex_pc=0x100, Br_eq=1, ex_pred_taken=0 -> PC_sel=01, mispredict=1; next cycle if_pc=0x100 gives if_pred_taken=1 (counter 10).
- Same BEQ taken 3 more times, then Br_eq=0 with ex_pred_taken=1 -> PC_sel=11, mispredict=1; counter goes 11->10 and prediction remains 1.
- BLTU (funct3 110) -> Br_un=1; Br_lt=0, ex_pred_taken=0 -> PC_sel=00, counter decrements from 01 to 00, then saturates at 00 on a repeat.
- JALR with ex_valid=1 -> PC_sel=10, no BHT change; funct3=010 branch -> illegal_br=1, PC_sel=00; ex_valid=0 -> all outputs 0.
- Update to idx 5 asserted in the same cycle as rst=1 -> array reads 01 next cycle; with BPU_STATS_EN, stat_branches=0 afterwards.

Source files
------------

// File: rtl/branch_resolve_predict.sv
// rtl/branch_resolve_predict.sv - bimodal BHT predictor with execute-stage branch resolution and PC select; optional BPU_STATS_EN statistics counters
module branch_resolve_predict #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_W       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [31:0]     ex_instr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic            Br_eq,
    input  logic            Br_lt,
    output logic            Br_un,
    output logic [1:0]      PC_sel,
    output logic            mispredict,
    output logic            illegal_br
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred,
    output logic [31:0]     stat_jalr
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN  = '0;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SEL_NONE    = 2'b00;
    localparam logic [1:0] SEL_TARGET  = 2'b01;
    localparam logic [1:0] SEL_JALR    = 2'b10;
    localparam logic [1:0] SEL_RECOVER = 2'b11;

    logic [CTR_W-1:0] bht [BHT_ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic             br_legal;
    logic             br_taken;
    logic             train_en;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_next;
    logic             unused_bits;

    // Word-aligned PCs: drop the two low bits, no tag, aliasing tolerated
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_bits = ^{if_pc, ex_pc, ex_instr};

    assign opcode    = ex_instr[6:0];
    assign funct3    = ex_instr[14:12];
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign br_legal  = is_branch && (funct3 != 3'b010) && (funct3 != 3'b011);
    assign train_en  = ex_valid && br_legal;

    // Fetch prediction straight from the array; no bypass of a same-cycle update
    always_comb begin
        if_pred_taken = 1'b0;
        if (if_valid) begin
            if_pred_taken = bht[if_idx][CTR_W-1];
        end
    end

    // Actual branch outcome from the comparator flags
    always_comb begin
        br_taken = 1'b0;
        if (is_branch) begin
            case (funct3)
                3'b000:         br_taken = Br_eq;
                3'b001:         br_taken = !Br_eq;
                3'b100, 3'b110: br_taken = Br_lt;
                3'b101, 3'b111: br_taken = !Br_lt;
                default:        br_taken = 1'b0;
            endcase
        end
    end

    // Redirect select, mispredict and illegal flag; all quiet when the slot is empty
    always_comb begin
        PC_sel     = SEL_NONE;
        illegal_br = 1'b0;
        Br_un      = is_branch && funct3[1];
        if (ex_valid) begin
            if (is_branch) begin
                if (!br_legal) begin
                    illegal_br = 1'b1;
                end else if (br_taken && !ex_pred_taken) begin
                    PC_sel = SEL_TARGET;
                end else if (!br_taken && ex_pred_taken) begin
                    PC_sel = SEL_RECOVER;
                end
            end else if (is_jal) begin
                if (!ex_pred_taken) begin
                    PC_sel = SEL_TARGET;
                end
            end else if (is_jalr) begin
                PC_sel = SEL_JALR;
            end
        end
        mispredict = ex_valid && (PC_sel != SEL_NONE);
    end

    // Saturating next value for the counter being trained
    always_comb begin
        ctr_cur  = bht[ex_idx];
        ctr_next = ctr_cur;
        if (br_taken) begin
            if (ctr_cur != CTR_MAX) begin
                ctr_next = ctr_cur + CTR_W'(1);
            end
        end else begin
            if (ctr_cur != CTR_MIN) begin
                ctr_next = ctr_cur - CTR_W'(1);
            end
        end
    end

    // Counter array: reset wipes every entry at once and beats a same-cycle update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (train_en) begin
            bht[ex_idx] <= ctr_next;
        end
    end

`ifdef BPU_STATS_EN
    // Statistics counters, stepped on the training edge and wrapping freely
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
            stat_jalr     <= '0;
        end else if (ex_valid) begin
            if (br_legal) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if ((is_branch || is_jal) && mispredict) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
            if (is_jalr) begin
                stat_jalr <= stat_jalr + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_predict.sv
// tb/tb_branch_resolve_predict.sv - scoreboard bench for branch_resolve_predict
module tb_branch_resolve_predict;

    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_BNE  = 32'h0000_1063;
    localparam logic [31:0] I_BR2  = 32'h0000_2063;
    localparam logic [31:0] I_BR3  = 32'h0000_3063;
    localparam logic [31:0] I_BGE  = 32'h0000_5063;
    localparam logic [31:0] I_BLTU = 32'h0000_6063;
    localparam logic [31:0] I_JAL  = 32'h0000_006f;
    localparam logic [31:0] I_JALR = 32'h0000_0067;
    localparam logic [31:0] I_ADD  = 32'h0000_0033;

    localparam int K_OTHER  = 0;
    localparam int K_BRANCH = 1;
    localparam int K_JAL    = 2;
    localparam int K_JALR   = 3;
    localparam int K_ILL    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        Br_eq;
    logic        Br_lt;
    logic        Br_un;
    logic [1:0]  PC_sel;
    logic        mispredict;
    logic        illegal_br;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
    logic [31:0] stat_jalr;
`endif

    typedef struct {
        logic [1:0] sel;
        logic       mis;
        logic       ill;
        logic       un;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    int exp_branches = 0;
    int exp_mispred  = 0;
    int exp_jalr     = 0;

    branch_resolve_predict #(
        .XLEN(32),
        .BHT_ENTRIES(64),
        .CTR_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid),
        .ex_instr(ex_instr),
        .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken),
        .Br_eq(Br_eq),
        .Br_lt(Br_lt),
        .Br_un(Br_un),
        .PC_sel(PC_sel),
        .mispredict(mispredict),
        .illegal_br(illegal_br)
`ifdef BPU_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispred(stat_mispred),
        .stat_jalr(stat_jalr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc, input logic valid, input logic exp);
        if_valid = valid;
        if_pc    = pc;
        #1;
        check(tag, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    // One execute-slot instruction: drive, push expectation, compare mid-cycle, let the update edge pass
    task automatic ex_op(input string tag, input logic valid, input logic [31:0] instr,
                         input logic [31:0] pc, input logic pred, input logic eq, input logic lt,
                         input logic [1:0] e_sel, input logic e_mis, input logic e_ill,
                         input logic e_un, input int kind);
        exp_t e;
        @(posedge clk);
        #1;
        ex_valid      = valid;
        ex_instr      = instr;
        ex_pc         = pc;
        ex_pred_taken = pred;
        Br_eq         = eq;
        Br_lt         = lt;
        sb.push_back('{sel: e_sel, mis: e_mis, ill: e_ill, un: e_un});
        if (valid) begin
            if (kind == K_BRANCH) exp_branches++;
            if ((kind == K_BRANCH || kind == K_JAL) && e_mis) exp_mispred++;
            if (kind == K_JALR) exp_jalr++;
        end
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_pc_sel"}, {30'd0, PC_sel}, {30'd0, e.sel});
            check({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, e.mis});
            check({tag, "_illegal_br"}, {31'd0, illegal_br}, {31'd0, e.ill});
            check({tag, "_br_un"}, {31'd0, Br_un}, {31'd0, e.un});
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef BPU_STATS_EN
        check({tag, "_stat_branches"}, stat_branches, exp_branches);
        check({tag, "_stat_mispred"}, stat_mispred, exp_mispred);
        check({tag, "_stat_jalr"}, stat_jalr, exp_jalr);
`else
        check({tag, "_no_stats_pending_sb"}, sb.size(), 0);
`endif
    endtask

    initial begin
        rst           = 1'b1;
        if_valid      = 1'b0;
        if_pc         = '0;
        ex_valid      = 1'b0;
        ex_instr      = '0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;
        Br_eq         = 1'b0;
        Br_lt         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        fetch("reset_pred_0x100", 32'h100, 1'b1, 1'b0);
        fetch("pred_gated_by_if_valid", 32'h100, 1'b0, 1'b0);
        check_stats("after_reset");

        ex_op("beq_taken_mispred", 1, I_BEQ, 32'h100, 0, 1, 0, 2'b01, 1, 0, 0, K_BRANCH);
        fetch("pred_after_first_taken", 32'h100, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ex_op("beq_taken_correct", 1, I_BEQ, 32'h100, 1, 1, 0, 2'b00, 0, 0, 0, K_BRANCH);
        end
        ex_op("beq_not_taken_recover", 1, I_BEQ, 32'h100, 1, 0, 0, 2'b11, 1, 0, 0, K_BRANCH);
        fetch("pred_after_11_to_10", 32'h100, 1'b1, 1'b1);

        ex_op("bltu_not_taken", 1, I_BLTU, 32'h204, 0, 0, 0, 2'b00, 0, 0, 1, K_BRANCH);
        ex_op("bltu_not_taken_sat", 1, I_BLTU, 32'h204, 0, 0, 0, 2'b00, 0, 0, 1, K_BRANCH);
        fetch("pred_bltu_at_00", 32'h204, 1'b1, 1'b0);
        ex_op("bltu_taken_from_00", 1, I_BLTU, 32'h204, 0, 0, 1, 2'b01, 1, 0, 1, K_BRANCH);
        fetch("pred_saturated_then_01", 32'h204, 1'b1, 1'b0);
        ex_op("bltu_taken_to_10", 1, I_BLTU, 32'h204, 0, 0, 1, 2'b01, 1, 0, 1, K_BRANCH);
        fetch("pred_bltu_at_10", 32'h204, 1'b1, 1'b1);

        ex_op("bge_not_taken_recover", 1, I_BGE, 32'h308, 1, 0, 1, 2'b11, 1, 0, 0, K_BRANCH);
        ex_op("bne_not_taken_ok", 1, I_BNE, 32'h308, 0, 1, 0, 2'b00, 0, 0, 0, K_BRANCH);
        fetch("pred_bge_bne_idx", 32'h308, 1'b1, 1'b0);

        ex_op("jalr_redirect", 1, I_JALR, 32'h204, 0, 0, 0, 2'b10, 1, 0, 0, K_JALR);
        ex_op("jal_unpredicted", 1, I_JAL, 32'h204, 0, 0, 0, 2'b01, 1, 0, 0, K_JAL);
        ex_op("jal_predicted", 1, I_JAL, 32'h204, 1, 0, 0, 2'b00, 0, 0, 0, K_JAL);
        fetch("pred_after_jumps", 32'h204, 1'b1, 1'b1);

        ex_op("branch_f3_010", 1, I_BR2, 32'h204, 0, 1, 1, 2'b00, 0, 1, 1, K_ILL);
        ex_op("branch_f3_011", 1, I_BR3, 32'h204, 1, 0, 0, 2'b00, 0, 1, 1, K_ILL);
        fetch("pred_after_illegal", 32'h204, 1'b1, 1'b1);

        ex_op("non_branch", 1, I_ADD, 32'h100, 1, 1, 1, 2'b00, 0, 0, 0, K_OTHER);
        ex_op("ex_invalid", 0, I_BEQ, 32'h100, 1, 0, 0, 2'b00, 0, 0, 0, K_BRANCH);
        fetch("pred_after_invalid", 32'h100, 1'b1, 1'b1);

        ex_op("beq_idx5_taken", 1, I_BEQ, 32'h14, 0, 1, 0, 2'b01, 1, 0, 0, K_BRANCH);
        fetch("pred_idx5_trained", 32'h14, 1'b1, 1'b1);
        check_stats("before_reset");

        // Update and reset on the same edge: reset must win
        @(posedge clk);
        #1;
        rst           = 1'b1;
        ex_valid      = 1'b1;
        ex_instr      = I_BEQ;
        ex_pc         = 32'h14;
        ex_pred_taken = 1'b0;
        Br_eq         = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        ex_valid     = 1'b0;
        exp_branches = 0;
        exp_mispred  = 0;
        exp_jalr     = 0;
        fetch("pred_idx5_after_rst", 32'h14, 1'b1, 1'b0);
        fetch("pred_idx0_after_rst", 32'h100, 1'b1, 1'b0);
        check_stats("after_rst_update");

        ex_op("beq_idx5_post_rst", 1, I_BEQ, 32'h14, 0, 1, 0, 2'b01, 1, 0, 0, K_BRANCH);
        fetch("pred_idx5_was_01", 32'h14, 1'b1, 1'b1);
        check_stats("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
